// File: rtl/ifetch.sv
// Instruction fetch: one word per request, JAL/BHT next-PC prediction, JALR halt,
// and a small instruction queue whose head feeds the decoder combinationally.
module ifetch #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned BHT_BITS = 6,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic [31:0] clear_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data,
    output logic        dec_ok,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_ins,
    output logic        dec_jp,
    input  logic        issue_stall,
    input  logic        jalr_ok,
    input  logic [31:0] jalr_pc,
    input  logic        bp_upd,
    input  logic [31:0] bp_pc,
    input  logic        bp_taken
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned BHT_N = 1 << BHT_BITS;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HALT
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        jp;
        logic        is_jalr;
    } entry_t;

    state_t              r_state;
    state_t              w_state_n;
    logic [31:0]         r_pc;
    logic [31:0]         w_pc_n;

    entry_t              r_q [DEPTH];
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [CNT_W-1:0]    r_count;

    logic [1:0]          r_bht [BHT_N];

    entry_t              w_head;
    entry_t              w_new;
    logic                w_dec_ok;
    logic                w_pop;
    logic                w_push;
    logic [BHT_BITS-1:0] w_lk_idx;
    logic [BHT_BITS-1:0] w_up_idx;
    logic [31:0]         w_j_imm;
    logic [31:0]         w_b_imm;
    logic                w_unused;

    assign w_unused = ^{bp_pc[31:BHT_BITS+2], bp_pc[1:0]};

    // Queue head and pop qualification.
    assign w_dec_ok = (r_count != '0);
    assign w_head   = r_q[r_head];
    assign w_pop    = w_dec_ok && !issue_stall && (!w_head.is_jalr || jalr_ok) && rdy && !clear;

    assign dec_ok  = w_dec_ok;
    assign dec_pc  = w_dec_ok ? w_head.pc  : 32'h0;
    assign dec_ins = w_dec_ok ? w_head.ins : 32'h0;
    assign dec_jp  = w_dec_ok ? w_head.jp  : 1'b0;

    assign mem_req  = (r_state == S_WAIT);
    assign mem_addr = {r_pc[31:2], 2'b00};

    // Predecode immediates of the returning word.
    assign w_j_imm  = {{12{mem_data[31]}}, mem_data[19:12], mem_data[20], mem_data[30:21], 1'b0};
    assign w_b_imm  = {{20{mem_data[31]}}, mem_data[7], mem_data[30:25], mem_data[11:8], 1'b0};
    assign w_lk_idx = r_pc[BHT_BITS+1:2];
    assign w_up_idx = bp_pc[BHT_BITS+1:2];

    // Fetch FSM next state, next PC and queue push.
    always_comb begin
        w_state_n   = r_state;
        w_pc_n      = r_pc;
        w_push      = 1'b0;
        w_new       = '0;
        w_new.pc    = r_pc;
        w_new.ins   = mem_data;
        case (r_state)
            S_IDLE: begin
                if ((r_count < CNT_W'(DEPTH)) || w_pop) begin
                    w_state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_done) begin
                    w_push    = 1'b1;
                    w_state_n = S_IDLE;
                    case (mem_data[6:0])
                        OP_JAL: begin
                            w_pc_n   = r_pc + w_j_imm;
                            w_new.jp = 1'b1;
                        end
                        OP_BRANCH: begin
                            if (r_bht[w_lk_idx][1]) begin
                                w_pc_n   = r_pc + w_b_imm;
                                w_new.jp = 1'b1;
                            end else begin
                                w_pc_n = r_pc + 32'd4;
                            end
                        end
                        OP_JALR: begin
                            w_new.is_jalr = 1'b1;
                            w_state_n     = S_HALT;
                        end
                        default: w_pc_n = r_pc + 32'd4;
                    endcase
                end
            end
            S_HALT: begin
                if (jalr_ok) begin
                    w_pc_n    = jalr_pc;
                    w_state_n = S_IDLE;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
        // A flush redirects fetch and drops any word returning in the same cycle.
        if (clear) begin
            w_state_n = S_IDLE;
            w_pc_n    = clear_pc;
            w_push    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
        end else if (rdy) begin
            r_state <= w_state_n;
            r_pc    <= w_pc_n;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rdy) begin
            if (clear) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + PTR_W'(1);
                end
                if (w_pop) begin
                    r_head <= r_head + PTR_W'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CNT_W'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && w_push) begin
            r_q[r_tail] <= w_new;
        end
    end

    // Branch history: 2-bit saturating counters trained at commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < BHT_N; i++) begin
                r_bht[i[BHT_BITS-1:0]] <= 2'b01;
            end
        end else if (rdy && bp_upd) begin
            if (bp_taken) begin
                if (r_bht[w_up_idx] != 2'b11) begin
                    r_bht[w_up_idx] <= r_bht[w_up_idx] + 2'd1;
                end
            end else begin
                if (r_bht[w_up_idx] != 2'b00) begin
                    r_bht[w_up_idx] <= r_bht[w_up_idx] - 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: hand-built program, 2-cycle memory responder,
// expected decode stream and request addresses queued by the stimulus.
module tb_ifetch;
    localparam int MEM_LAT = 2;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        clear;
    logic [31:0] clear_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;
    logic        dec_ok;
    logic [31:0] dec_pc;
    logic [31:0] dec_ins;
    logic        dec_jp;
    logic        issue_stall;
    logic        jalr_ok;
    logic [31:0] jalr_pc;
    logic        bp_upd;
    logic [31:0] bp_pc;
    logic        bp_taken;

    ifetch #(.DEPTH(8), .BHT_BITS(6), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .clear_pc(clear_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_done(mem_done), .mem_data(mem_data),
        .dec_ok(dec_ok), .dec_pc(dec_pc), .dec_ins(dec_ins), .dec_jp(dec_jp),
        .issue_stall(issue_stall), .jalr_ok(jalr_ok), .jalr_pc(jalr_pc),
        .bp_upd(bp_upd), .bp_pc(bp_pc), .bp_taken(bp_taken)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        jp;
        logic        jalr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_pops   = 0;

    // Clear requests from the stimulus, executed by the responder (sole driver of clear).
    int          clr_req  = 0;
    int          clr_ack  = 0;
    bit          clr_on_done = 1'b0;
    logic [31:0] clr_pc_req = 32'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h000: imem = 32'h00100093;
            32'h004: imem = 32'h00200113;
            32'h008: imem = 32'h00300193;
            32'h00C: imem = 32'h00400213;
            32'h010: imem = 32'h0400006F;
            32'h050: imem = 32'h00008067;
            32'h020: imem = 32'hFE000CE3;
            32'h030: imem = 32'h00008067;
            32'h200: imem = 32'hE21FF06F;
            default: imem = 32'h00000013 | {a[11:0], 20'h0};
        endcase
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic exp_ent(input logic [31:0] pc, input logic jp, input logic jalr);
        exp_q.push_back('{pc: pc, ins: imem(pc), jp: jp, jalr: jalr});
        addr_q.push_back(pc);
    endtask

    task automatic exp_loop(input int n);
        for (int i = 0; i < n; i++) begin
            case (i % 3)
                0:       exp_ent(32'h20, 1'b1, 1'b0);
                1:       exp_ent(32'h18, 1'b0, 1'b0);
                default: exp_ent(32'h1C, 1'b0, 1'b0);
            endcase
        end
    endtask

    task automatic wait_head(input logic [31:0] pc, input string name);
        int t = 0;
        while (!(dec_ok && dec_pc == pc) && t < 200) begin
            tick();
            t++;
        end
        check(name, 96'(t < 200), 96'(1));
    endtask

    task automatic wait_clear_ack(input string name);
        int t = 0;
        while (clr_ack != clr_req && t < 100) begin
            tick();
            t++;
        end
        check(name, 96'(t < 100), 96'(1));
    endtask

    // Memory responder: fixed latency, aborts on clear/rst, checks request addresses.
    initial begin : responder
        bit          busy = 1'b0;
        int          lat  = 0;
        logic [31:0] cur  = 32'h0;
        clear    = 1'b0;
        clear_pc = 32'h0;
        mem_done = 1'b0;
        mem_data = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            clear    = 1'b0;
            mem_done = 1'b0;
            if (clr_req != clr_ack && !clr_on_done) begin
                clear    = 1'b1;
                clear_pc = clr_pc_req;
                exp_q.delete();
                addr_q.delete();
                busy     = 1'b0;
                clr_ack  = clr_req;
            end else if (rst) begin
                busy = 1'b0;
            end else if (mem_req) begin
                if (!busy) begin
                    if (addr_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL mem_addr_unexpected actual=%0h required=none", mem_addr);
                    end else begin
                        check("mem_addr", 96'(mem_addr), 96'(addr_q.pop_front()));
                    end
                    cur  = mem_addr;
                    busy = 1'b1;
                    lat  = 0;
                end else begin
                    check("mem_addr_stable", 96'(mem_addr), 96'(cur));
                end
                lat++;
                if (lat == MEM_LAT) begin
                    mem_done = 1'b1;
                    mem_data = imem(cur);
                    busy     = 1'b0;
                    if (clr_req != clr_ack && clr_on_done) begin
                        clear       = 1'b1;
                        clear_pc    = clr_pc_req;
                        exp_q.delete();
                        addr_q.delete();
                        clr_on_done = 1'b0;
                        clr_ack     = clr_req;
                    end
                end
            end
        end
    end

    // Monitor: compares every consumed head against the scoreboard.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (!rst && rdy && !clear && dec_ok && !issue_stall) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL dec_unexpected actual=%0h required=none", dec_pc);
                end else if (!exp_q[0].jalr || jalr_ok) begin
                    e = exp_q.pop_front();
                    check("dec_entry", 96'({dec_pc, dec_ins, dec_jp}), 96'({e.pc, e.ins, e.jp}));
                    n_pops++;
                end
            end
        end
    end

    initial begin : stimulus
        int p0;
        rst = 1'b1; rdy = 1'b1; issue_stall = 1'b0;
        jalr_ok = 1'b0; jalr_pc = 32'h0;
        bp_upd = 1'b0; bp_pc = 32'h0; bp_taken = 1'b0;
        repeat (3) tick();
        check("rst_mem_req",  96'(mem_req),  96'(0));
        check("rst_mem_addr", 96'(mem_addr), 96'(32'h0));
        check("rst_dec_ok",   96'(dec_ok),   96'(0));
        check("rst_dec_pc",   96'(dec_pc),   96'(32'h0));
        check("rst_dec_ins",  96'(dec_ins),  96'(32'h0));
        check("rst_dec_jp",   96'(dec_jp),   96'(0));

        // Sequential ADDIs, JAL +0x40, JALR halts.
        exp_ent(32'h00, 1'b0, 1'b0);
        exp_ent(32'h04, 1'b0, 1'b0);
        exp_ent(32'h08, 1'b0, 1'b0);
        exp_ent(32'h0C, 1'b0, 1'b0);
        exp_ent(32'h10, 1'b1, 1'b0);
        exp_ent(32'h50, 1'b0, 1'b1);
        rst = 1'b0;
        wait_head(32'h50, "reach_jalr_a");
        repeat (4) tick();
        check("halt_a_hold", 96'({mem_req, dec_ok, dec_pc}), 96'({1'b0, 1'b1, 32'h50}));
        check("halt_a_scoreboard", 96'(exp_q.size()), 96'(1));

        // rdy=0 freezes everything, including jalr_ok handling.
        rdy = 1'b0; jalr_ok = 1'b1; jalr_pc = 32'h20;
        repeat (2) tick();
        check("rdy_hold", 96'({mem_req, dec_ok, dec_pc}), 96'({1'b0, 1'b1, 32'h50}));
        // Untrained BEQ at 0x20 is predicted not taken.
        exp_ent(32'h20, 1'b0, 1'b0);
        exp_ent(32'h24, 1'b0, 1'b0);
        exp_ent(32'h28, 1'b0, 1'b0);
        exp_ent(32'h2C, 1'b0, 1'b0);
        exp_ent(32'h30, 1'b0, 1'b1);
        rdy = 1'b1;
        tick();
        jalr_ok = 1'b0;
        wait_head(32'h30, "reach_jalr_b");
        repeat (3) tick();
        check("halt_b_hold", 96'({mem_req, dec_ok, dec_pc}), 96'({1'b0, 1'b1, 32'h30}));

        // Train the BHT entry for 0x20 taken three times (saturates at 3).
        bp_upd = 1'b1; bp_pc = 32'h20; bp_taken = 1'b1;
        repeat (3) tick();
        bp_upd = 1'b0;
        exp_loop(20);
        jalr_ok = 1'b1; jalr_pc = 32'h20;
        tick();
        jalr_ok = 1'b0; issue_stall = 1'b1;
        repeat (60) tick();
        check("full_requests", 96'(addr_q.size()), 96'(12));
        check("full_no_req", 96'({mem_req, dec_ok, dec_pc, dec_jp}), 96'({1'b0, 1'b1, 32'h20, 1'b1}));
        check("full_no_pop", 96'(exp_q.size()), 96'(20));

        // Release: one pop per cycle.
        p0 = n_pops;
        issue_stall = 1'b0;
        repeat (8) tick();
        check("drain_rate", 96'(n_pops - p0), 96'(8));
        issue_stall = 1'b1;

        // Clear coinciding with mem_done; BHT must survive.
        clr_pc_req = 32'h200; clr_on_done = 1'b1; clr_req++;
        wait_clear_ack("clear_done_seen");
        check("clear_outputs", 96'({mem_req, dec_ok, dec_pc, dec_ins, dec_jp}), 96'(0));
        exp_ent(32'h200, 1'b1, 1'b0);
        exp_loop(12);
        issue_stall = 1'b0;
        p0 = n_pops;
        repeat (15) tick();
        check("post_clear_pops", 96'(n_pops - p0 >= 3), 96'(1));

        // Two not-taken updates bring 3 down to 1, then redirect to 0x20.
        issue_stall = 1'b1;
        bp_upd = 1'b1; bp_pc = 32'h20; bp_taken = 1'b0;
        repeat (2) tick();
        bp_upd = 1'b0;
        clr_pc_req = 32'h20; clr_on_done = 1'b0; clr_req++;
        tick();
        wait_clear_ack("clear_imm_seen");
        exp_ent(32'h20, 1'b0, 1'b0);
        exp_ent(32'h24, 1'b0, 1'b0);
        exp_ent(32'h28, 1'b0, 1'b0);
        exp_ent(32'h2C, 1'b0, 1'b0);
        exp_ent(32'h30, 1'b0, 1'b1);
        issue_stall = 1'b0;
        wait_head(32'h30, "reach_jalr_e");
        repeat (3) tick();
        check("final_scoreboard", 96'(exp_q.size()), 96'(1));
        check("final_addrs", 96'(addr_q.size()), 96'(0));
        check("final_no_req", 96'(mem_req), 96'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
